// File: rtl/vga_sync_rx.sv
// VGA timing receiver: samples sync/RGB pins on the pixel strobe, recovers x/y/de,
// measures line and frame lengths and tracks lock against the expected video mode.
module vga_sync_rx #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_TOTAL     = 800,
    parameter int   H_START     = 144,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_TOTAL     = 525,
    parameter int   V_START     = 35,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_e;

    localparam logic [10:0] H_TOT_C = 11'(H_TOTAL);
    localparam logic [10:0] H_ST_C  = 11'(H_START);
    localparam logic [10:0] H_END_C = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_TOT_C = 11'(V_TOTAL);
    localparam logic [10:0] V_ST_C  = 11'(V_START);
    localparam logic [10:0] V_END_C = 11'(V_START + V_ACTIVE);
    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [7:0]  LOCK_C  = 8'(LOCK_FRAMES);

    // Pipeline word layout: {hs asserted, vs asserted, rgb}
    logic [13:0] s1_q, s1_d, s2_q, s2_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [11:0] rgb_out_q, rgb_out_d;
    logic        de_q, de_d, frame_start_q, frame_start_d;
    logic        vpend_q, vpend_d, line_chk_q, line_chk_d, frame_bad_q, frame_bad_d;
    logic        locked_q, locked_d;
    logic [7:0]  err_cnt_q, err_cnt_d, lock_cnt_q, lock_cnt_d;
    lock_state_e state_q, state_d;

    logic hs_a, vs_a, h_edge, v_edge, frame_evt, loss, bad_line, bad_frame, in_win;

    assign hs_a      = (hsync_in == SYNC_POL);
    assign vs_a      = (vsync_in == SYNC_POL);
    assign h_edge    = pix_en & s1_q[13] & ~s2_q[13];
    assign v_edge    = pix_en & s1_q[12] & ~s2_q[12];
    assign frame_evt = h_edge & (vpend_q | v_edge);
    // Loss is flagged only on the strobe that pushes a counter into saturation.
    assign loss      = (pix_en & ~h_edge & (hcnt_q == CNT_MAX - 11'd1)) |
                       (h_edge & ~frame_evt & (vcnt_q == CNT_MAX - 11'd1));
    assign bad_line  = h_edge & line_chk_q & ((hcnt_q + 11'd1) != H_TOT_C);
    assign bad_frame = frame_evt & (((vcnt_q + 11'd1) != V_TOT_C) | frame_bad_q | bad_line);
    assign in_win    = (hcnt_q >= H_ST_C) && (hcnt_q < H_END_C) &&
                       (vcnt_q >= V_ST_C) && (vcnt_q < V_END_C);

    always_comb begin
        s1_d          = s1_q;
        s2_d          = s2_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        rgb_out_d     = rgb_out_q;
        vpend_d       = vpend_q;
        line_chk_d    = line_chk_q;
        frame_bad_d   = frame_bad_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            s1_d      = {hs_a, vs_a, rgb_in};
            s2_d      = s1_q;
            x_d       = in_win ? 10'(hcnt_q - H_ST_C) : 10'd0;
            y_d       = in_win ? 10'(vcnt_q - V_ST_C) : 10'd0;
            de_d      = in_win & locked_q;
            rgb_out_d = s2_q[11:0];
            if (h_edge) begin
                hcnt_d     = 11'd0;
                line_len_d = hcnt_q + 11'd1;
                line_chk_d = 1'b1;
            end else if (hcnt_q != CNT_MAX) begin
                hcnt_d = hcnt_q + 11'd1;
            end
            if (frame_evt) begin
                vcnt_d        = 11'd0;
                frame_lines_d = vcnt_q + 11'd1;
                vpend_d       = 1'b0;
                frame_bad_d   = 1'b0;
                frame_start_d = 1'b1;
            end else begin
                if (h_edge) begin
                    if (vcnt_q != CNT_MAX) begin
                        vcnt_d = vcnt_q + 11'd1;
                    end
                    frame_bad_d = frame_bad_q | bad_line;
                end
                if (v_edge) begin
                    vpend_d = 1'b1;
                end
            end
            if (loss) begin
                line_chk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            rgb_out_q     <= '0;
            vpend_q       <= 1'b0;
            line_chk_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            rgb_out_q     <= rgb_out_d;
            vpend_q       <= vpend_d;
            line_chk_q    <= line_chk_d;
            frame_bad_q   <= frame_bad_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Lock tracking; locked follows the state one clk later so it rises after frame_start.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        err_cnt_d  = err_cnt_q;
        locked_d   = (state_q == LOCKED);
        if (loss) begin
            state_d    = SEARCH;
            lock_cnt_d = 8'd0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (frame_evt) begin
                        state_d    = TRACK;
                        lock_cnt_d = 8'd0;
                    end
                end
                TRACK: begin
                    if (bad_line | bad_frame) begin
                        lock_cnt_d = 8'd0;
                    end else if (frame_evt) begin
                        if (lock_cnt_q + 8'd1 >= LOCK_C) begin
                            state_d    = LOCKED;
                            lock_cnt_d = 8'd0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_line | bad_frame) begin
                        state_d    = TRACK;
                        lock_cnt_d = 8'd0;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            lock_cnt_q <= '0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign rgb_out     = rgb_out_q;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx: a sample-level reference model predicts every strobe's
// outputs, a monitor pops and compares them as the DUT presents each new pixel.
module tb_vga_sync_rx;

    localparam int   H_ACTIVE    = 16;
    localparam int   H_TOTAL     = 40;
    localparam int   H_START     = 12;
    localparam int   V_ACTIVE    = 6;
    localparam int   V_TOTAL     = 12;
    localparam int   V_START     = 3;
    localparam logic SYNC_POL    = 1'b0;
    localparam int   LOCK_FRAMES = 2;
    localparam int   HSYNC_W     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] rgb_in = '0;
    logic [9:0]  x, y;
    logic        de, frame_start, locked;
    logic [11:0] rgb_out;
    logic [10:0] line_len, frame_lines;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .H_START(H_START),
        .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .V_START(V_START),
        .SYNC_POL(SYNC_POL), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .x(x), .y(y), .de(de), .rgb_out(rgb_out), .frame_start(frame_start),
        .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [9:0]  x, y;
        logic        de;
        logic [11:0] rgb;
        logic [10:0] line_len, frame_lines;
        logic        locked;
        logic [7:0]  errs;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;
    int   strobes = 0;
    int   fs_seen = 0;

    // Reference model state, expressed in pin-sample terms.
    int   m_hpos, m_vpos, m_line_len, m_frame_lines, m_good, m_errs;
    bit   m_prev_hs, m_prev_vs, m_vpend, m_chk, m_frame_bad, m_search, m_locked;
    int   m_px, m_py;
    bit   m_pde;
    logic [11:0] m_prgb;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vectors++;
        if (act !== req) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_hpos = 1; m_vpos = 0; m_line_len = 0; m_frame_lines = 0; m_good = 0; m_errs = 0;
        m_prev_hs = 0; m_prev_vs = 0; m_vpend = 0; m_chk = 0; m_frame_bad = 0;
        m_search = 1; m_locked = 0;
        m_px = 0; m_py = 0; m_pde = 0; m_prgb = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb);
        exp_t e;
        bit hedge, vedge, fs, bad_line, bad_frame, loss, in_win;
        hedge = hs && !m_prev_hs;
        vedge = vs && !m_prev_vs;
        m_prev_hs = hs;
        m_prev_vs = vs;
        fs = 0; bad_line = 0; bad_frame = 0; loss = 0;
        if (hedge) begin
            bad_line   = m_chk && (m_hpos + 1 != H_TOTAL);
            m_chk      = 1;
            m_line_len = (m_hpos + 1) % 2048;
            m_hpos     = 0;
            if (m_vpend || vedge) begin
                fs            = 1;
                m_frame_lines = (m_vpos + 1) % 2048;
                bad_frame     = (m_vpos + 1 != V_TOTAL) || m_frame_bad || bad_line;
                m_vpos = 0; m_vpend = 0; m_frame_bad = 0;
            end else begin
                if (m_vpos == 2046) loss = 1;
                if (m_vpos < 2047) m_vpos++;
                m_frame_bad = m_frame_bad || bad_line;
                if (vedge) m_vpend = 1;
            end
        end else begin
            if (m_hpos == 2046) loss = 1;
            if (m_hpos < 2047) m_hpos++;
            if (vedge) m_vpend = 1;
        end
        if (loss) begin
            m_search = 1; m_locked = 0; m_good = 0; m_chk = 0;
            if (m_errs < 255) m_errs++;
        end else if (m_search) begin
            if (fs) begin m_search = 0; m_good = 0; end
        end else if (m_locked) begin
            if (bad_line || bad_frame) begin
                m_locked = 0; m_good = 0;
                if (m_errs < 255) m_errs++;
            end
        end else if (bad_line || bad_frame) begin
            m_good = 0;
        end else if (fs) begin
            m_good++;
            if (m_good >= LOCK_FRAMES) begin m_locked = 1; m_good = 0; end
        end
        // Pixel outputs lag the status by one strobe, so this entry carries the previous pixel.
        e.x = 10'(m_px); e.y = 10'(m_py); e.de = m_pde; e.rgb = m_prgb;
        e.line_len = 11'(m_line_len); e.frame_lines = 11'(m_frame_lines);
        e.locked = m_locked; e.errs = 8'(m_errs); e.fs = fs;
        exp_q.push_back(e);
        in_win = (m_hpos >= H_START) && (m_hpos < H_START + H_ACTIVE) &&
                 (m_vpos >= V_START) && (m_vpos < V_START + V_ACTIVE);
        m_px   = in_win ? m_hpos - H_START : 0;
        m_py   = in_win ? m_vpos - V_START : 0;
        m_pde  = in_win && m_locked;
        m_prgb = rgb;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) strobes <= 0;
        else if (pix_en) strobes <= strobes + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) fs_seen = 0;
        else if (frame_start) fs_seen++;
        if (rst && pix_en && strobes >= 2) begin
            if (exp_q.size() == 0) begin
                check_output("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_output("x",           32'(x),           32'(e.x));
                check_output("y",           32'(y),           32'(e.y));
                check_output("de",          32'(de),          32'(e.de));
                check_output("rgb_out",     32'(rgb_out),     32'(e.rgb));
                check_output("line_len",    32'(line_len),    32'(e.line_len));
                check_output("frame_lines", 32'(frame_lines), 32'(e.frame_lines));
                check_output("locked",      32'(locked),      32'(e.locked));
                check_output("err_cnt",     32'(err_cnt),     32'(e.errs));
                check_output("frame_start_pulses", 32'(fs_seen), 32'(e.fs));
            end
            fs_seen = 0;
        end
    end

    task automatic apply_stimulus(input bit hs, input bit vs);
        int gap;
        logic [11:0] pix;
        gap = $urandom_range(2, 4);
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
        pix      = 12'($urandom);
        hsync_in = hs ? SYNC_POL : ~SYNC_POL;
        vsync_in = vs ? SYNC_POL : ~SYNC_POL;
        rgb_in   = pix;
        pix_en   = 1'b1;
        model_step(hs, vs, pix);
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic send_line(input int len, input bit vs);
        for (int p = 0; p < len; p++) apply_stimulus(p < HSYNC_W, vs);
    endtask

    task automatic send_frame(input int lines, input int short_line);
        for (int l = 0; l < lines; l++) send_line((l == short_line) ? H_TOTAL - 1 : H_TOTAL, l < 2);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_output("rst_x",           32'(x),           32'd0);
        check_output("rst_y",           32'(y),           32'd0);
        check_output("rst_de",          32'(de),          32'd0);
        check_output("rst_rgb_out",     32'(rgb_out),     32'd0);
        check_output("rst_frame_start", 32'(frame_start), 32'd0);
        check_output("rst_line_len",    32'(line_len),    32'd0);
        check_output("rst_frame_lines", 32'(frame_lines), 32'd0);
        check_output("rst_locked",      32'(locked),      32'd0);
        check_output("rst_err_cnt",     32'(err_cnt),     32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, limit 2000000", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        do_reset();
        $display("[TB] nominal frames");
        repeat (4) send_frame(V_TOTAL, -1);
        $display("[TB] one short line inside a locked frame");
        send_frame(V_TOTAL, 5);
        repeat (3) send_frame(V_TOTAL, -1);
        $display("[TB] one short frame");
        send_frame(V_TOTAL - 1, -1);
        repeat (3) send_frame(V_TOTAL, -1);
        $display("[TB] hsync withdrawn");
        repeat (2100) apply_stimulus(1'b0, 1'b0);
        repeat (4) send_frame(V_TOTAL, -1);
        $display("[TB] reset mid-line while locked");
        send_frame(3, -1);
        for (int p = 0; p < H_TOTAL / 2; p++) apply_stimulus(p < HSYNC_W, 1'b0);
        do_reset();
        for (int p = H_TOTAL / 2; p < H_TOTAL; p++) apply_stimulus(1'b0, 1'b0);
        for (int l = 4; l < V_TOTAL; l++) send_line(H_TOTAL, 1'b0);
        repeat (4) send_frame(V_TOTAL, -1);
        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
